// File: rtl/adc_stim_gen.sv
// ADC stimulus source: ramp / constant / PRBS / alternate patterns over NUM_CH packed lanes.
// Optional inter-beat gap counter enabled by defining ADC_STIM_GAP_EN.
module adc_stim_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned CH_OFFSET  = 1,
  parameter logic [31:0] LFSR_POLY  = 32'h0000_B400
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [1:0]                   mode,
  input  logic [DATA_WIDTH-1:0]        start_val,
  input  logic [DATA_WIDTH-1:0]        step,
  input  logic [CNT_WIDTH-1:0]         burst_len,
  input  logic [7:0]                   gap,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         beat_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DATA_WIDTH-1:0] PolyW  = LFSR_POLY[DATA_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]  CntOne = 1;
  localparam logic [DATA_WIDTH-1:0] DatOne = 1;

  function automatic logic [DATA_WIDTH-1:0] f_advance(input logic [1:0]            m,
                                                       input logic [DATA_WIDTH-1:0] v,
                                                       input logic [DATA_WIDTH-1:0] s);
    case (m)
      2'd0:    return v + s;
      2'd1:    return v;
      2'd2:    return (v >> 1) ^ (v[0] ? PolyW : '0);
      default: return ~v;
    endcase
  endfunction

  function automatic logic [NUM_CH*DATA_WIDTH-1:0] f_lanes(input logic [DATA_WIDTH-1:0] b);
    logic [NUM_CH*DATA_WIDTH-1:0] r;
    logic [31:0]                  off;
    r = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      off = k * CH_OFFSET;
      r[k*DATA_WIDTH +: DATA_WIDTH] = b + off[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  logic [1:0]                   r_state;
  logic [1:0]                   r_mode;
  logic [DATA_WIDTH-1:0]        r_step;
  logic [DATA_WIDTH-1:0]        r_base;
  logic [CNT_WIDTH-1:0]         r_len;
  logic [CNT_WIDTH-1:0]         r_idx;
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic [NUM_CH*DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_last;
  logic                         r_done;

  logic                         w_accept;
  logic [DATA_WIDTH-1:0]        w_seed;
  logic [DATA_WIDTH-1:0]        w_next_base;
  logic [CNT_WIDTH-1:0]         w_next_idx;
  logic                         w_next_last;

  always_comb begin
    w_accept    = r_valid & out_ready;
    // An all-zero PRBS seed would lock the LFSR at zero.
    w_seed      = (mode == 2'd2 && start_val == '0) ? DatOne : start_val;
    w_next_base = f_advance(r_mode, r_base, r_step);
    w_next_idx  = r_idx + CntOne;
    w_next_last = (r_len != '0) && (w_next_idx == r_len - CntOne);
  end

`ifdef ADC_STIM_GAP_EN
  logic [7:0] r_gap;
  logic [7:0] r_gap_cnt;
`else
  logic w_unused_gap;
  assign w_unused_gap = ^gap;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_step    <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
`ifdef ADC_STIM_GAP_EN
      r_gap     <= '0;
      r_gap_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_RUN;
            r_mode  <= mode;
            r_step  <= step;
            r_len   <= burst_len;
            r_base  <= w_seed;
            r_data  <= f_lanes(w_seed);
            r_valid <= 1'b1;
            r_last  <= (burst_len == CntOne);
            r_idx   <= '0;
            r_cnt   <= '0;
`ifdef ADC_STIM_GAP_EN
            r_gap     <= gap;
            r_gap_cnt <= '0;
`endif
          end
        end
        S_RUN: begin
          if (w_accept && r_cnt != '1) r_cnt <= r_cnt + CntOne;
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef ADC_STIM_GAP_EN
            r_gap_cnt <= '0;
`endif
          end else if (w_accept && r_last) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_accept) begin
            r_base <= w_next_base;
            r_data <= f_lanes(w_next_base);
            r_idx  <= w_next_idx;
            r_last <= w_next_last;
`ifdef ADC_STIM_GAP_EN
            if (r_gap != '0) begin
              r_valid   <= 1'b0;
              r_gap_cnt <= r_gap;
            end
`endif
          end
`ifdef ADC_STIM_GAP_EN
          // Gap in progress: the next beat is already staged in r_data.
          else if (!r_valid) begin
            if (r_gap_cnt <= 8'd1) begin
              r_valid   <= 1'b1;
              r_gap_cnt <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt - 8'd1;
            end
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_adc_stim_gen.sv
// Directed, table-driven bench for adc_stim_gen (4 lanes, lane offset 0x10).
module tb_adc_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, out_ready;
  logic [1:0]  mode;
  logic [15:0] start_val, step, burst_len;
  logic [7:0]  gap;
  logic [63:0] out_data;
  logic        out_valid, out_last, busy, done;
  logic [15:0] beat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_stim_gen #(
    .DATA_WIDTH(16),
    .NUM_CH    (4),
    .CNT_WIDTH (16),
    .CH_OFFSET (16),
    .LFSR_POLY (32'h0000_B400)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .start_val(start_val),
    .step     (step),
    .burst_len(burst_len),
    .gap      (gap),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt)
  );

  typedef struct {
    logic [1:0]       mode;
    logic [15:0]      sv;
    logic [15:0]      step;
    logic [15:0]      len;
    logic [2:0][15:0] e;  // e[0] = beat 0
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic kick(input logic [1:0] m, input logic [15:0] sv, input logic [15:0] st,
                      input logic [15:0] len);
    @(negedge clk);
    mode = m; start_val = sv; step = st; burst_len = len; start = 1'b1;
    @(negedge clk);
    // Scramble the inputs to prove they were latched at start.
    start = 1'b0; mode = ~m; start_val = ~sv; step = st + 16'd7; burst_len = len + 16'd5;
  endtask

  task automatic chk_done(input logic [15:0] cnt);
    chk("done_pulse", {62'd0, done, out_valid}, 64'b10);
    chk("done_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("done_clear", {61'd0, done, busy, out_valid}, 64'd0);
    chk("done_cnt", {48'd0, beat_cnt}, {48'd0, cnt});
  endtask

  vec_t vecs [7];
  logic [15:0] m;
  logic [15:0] exp_seq [7];
  logic        rdy_seq [7];
  int          bt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 16'h0000, 16'd100, 16'd3, {16'd200, 16'd100, 16'd0}};
    vecs[1] = '{2'd1, 16'h1234, 16'd9,   16'd3, {16'h1234, 16'h1234, 16'h1234}};
    vecs[2] = '{2'd2, 16'h0000, 16'd0,   16'd3, {16'h5A00, 16'hB400, 16'h0001}};
    vecs[3] = '{2'd3, 16'h00FF, 16'd0,   16'd3, {16'h00FF, 16'hFF00, 16'h00FF}};
    vecs[4] = '{2'd0, 16'hFFFE, 16'd3,   16'd3, {16'h0004, 16'h0001, 16'hFFFE}};
    vecs[5] = '{2'd2, 16'hACE1, 16'd0,   16'd2, {16'h0000, 16'hE270, 16'hACE1}};
    vecs[6] = '{2'd0, 16'h0042, 16'd5,   16'd1, {16'h0000, 16'h0000, 16'h0042}};

    rst_n = 1'b0; start = 0; abort = 0; out_ready = 1; mode = 0;
    start_val = 0; step = 0; burst_len = 0; gap = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_data[59:0], out_valid, out_last, busy, done}, 64'd0);
    chk("reset_cnt", {48'd0, beat_cnt}, 64'd0);
    rst_n = 1'b1;

    // Table: short bursts, ready held high.
    for (int v = 0; v < 7; v++) begin
      kick(vecs[v].mode, vecs[v].sv, vecs[v].step, vecs[v].len);
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        chk("vec_valid", {63'd0, out_valid}, 64'd1);
        chk("vec_data", {48'd0, out_data[15:0]}, {48'd0, vecs[v].e[i]});
        chk("vec_last", {63'd0, out_last}, {63'd0, (i == int'(vecs[v].len) - 1)});
        @(negedge clk);
      end
      chk_done(vecs[v].len);
    end

    // Long ramp 0..9900; a start pulse mid-burst must be ignored.
    kick(2'd0, 16'd0, 16'd100, 16'd100);
    for (int i = 0; i < 100; i++) begin
      start = 1'b0;
      chk("ramp_data", {48'd0, out_data[15:0]}, 64'(i * 100));
      chk("ramp_last", {62'd0, out_last, out_valid}, {62'd0, (i == 99), 1'b1});
      if (i == 50) begin start = 1'b1; start_val = 16'h7777; end
      @(negedge clk);
    end
    chk_done(16'd100);

    // Backpressure on beat 1 for three cycles.
    exp_seq = '{16'd5, 16'd6, 16'd6, 16'd6, 16'd6, 16'd7, 16'd8};
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    kick(2'd0, 16'd5, 16'd1, 16'd4);
    for (int i = 0; i < 7; i++) begin
      chk("bp_data", {48'd0, out_data[15:0]}, {48'd0, exp_seq[i]});
      chk("bp_last", {62'd0, out_last, out_valid}, {62'd0, (i == 6), 1'b1});
      if (i == 4) chk("bp_hold_cnt", {48'd0, beat_cnt}, 64'd1);
      out_ready = rdy_seq[i];
      @(negedge clk);
    end
    chk_done(16'd4);

    // Continuous PRBS from seed 0; abort lands together with an acceptance.
    kick(2'd2, 16'd0, 16'd0, 16'd0);
    m = 16'h0001;
    for (int i = 0; i < 40; i++) begin
      chk("prbs_data", {48'd0, out_data[15:0]}, {48'd0, m});
      chk("prbs_nolast", {62'd0, out_last, out_valid}, 64'd1);
      m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000);
      if (i == 39) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk("prbs_abort", {60'd0, busy, done, out_valid, out_last}, 64'd0);
    chk("prbs_abort_cnt", {48'd0, beat_cnt}, 64'd40);

    // Four lanes with wrap.
    kick(2'd1, 16'hFFF8, 16'd0, 16'd2);
    chk("lanes_b0", out_data, 64'h0028_0018_0008_FFF8);
    @(negedge clk);
    chk("lanes_b1", out_data, 64'h0028_0018_0008_FFF8);
    @(negedge clk);
    chk_done(16'd2);

    // Abort on beat 3 of 10, while that beat is still pending.
    kick(2'd0, 16'd0, 16'd1, 16'd10);
    for (int i = 0; i < 3; i++) begin
      chk("ab_data", {48'd0, out_data[15:0]}, 64'(i));
      @(negedge clk);
    end
    chk("ab_data3", {48'd0, out_data[15:0]}, 64'd3);
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    out_ready = 1'b1; abort = 1'b0;
    chk("ab_state", {60'd0, busy, done, out_valid, out_last}, 64'd0);
    chk("ab_cnt", {48'd0, beat_cnt}, 64'd3);
    @(negedge clk);
    chk("ab_nodone", {63'd0, done}, 64'd0);

    // start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; start_val = 16'h0; mode = 2'd0; burst_len = 16'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_idle", {62'd0, busy, out_valid}, 64'd0);
    @(negedge clk);
    chk("sa_idle2", {62'd0, busy, out_valid}, 64'd0);

    // Asynchronous reset mid-burst.
    kick(2'd0, 16'h0100, 16'd1, 16'd10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", out_data, 64'd0);
    chk("rst_mid_ctl", {60'd0, out_valid, out_last, busy, done}, 64'd0);
    chk("rst_mid_cnt", {48'd0, beat_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Gap of 2 between beats (ignored unless the gap feature is built in).
    begin
`ifdef ADC_STIM_GAP_EN
      localparam int GapCycles = 7;
      logic [6:0] pat;
      pat = 7'b1001001;
`else
      localparam int GapCycles = 3;
      logic [6:0] pat;
      pat = 7'b0000111;
`endif
      gap = 8'd2;
      kick(2'd0, 16'h0010, 16'd1, 16'd3);
      bt = 0;
      for (int i = 0; i < GapCycles; i++) begin
        chk("gap_valid", {63'd0, out_valid}, {63'd0, pat[i]});
        if (pat[i]) begin
          chk("gap_data", {48'd0, out_data[15:0]}, 64'(16 + bt));
          chk("gap_last", {63'd0, out_last}, {63'd0, (bt == 2)});
          bt++;
        end
        @(negedge clk);
      end
      chk_done(16'd3);
      gap = 8'd0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_stim_gen.md
Name: adc_stim_gen

Overview:
- Parametrised, synthesizable ADC stimulus generator for rf_frontend_top. It replaces the hard-coded "i*100" stimulus loop with run-time selectable patterns, burst control and a valid/ready source.
- Drives adc_data/adc_valid into the frontend, both in the bench and on-board in loopback mode.
- Generalises the stimulus to NUM_CH packed lanes, four pattern modes, finite or continuous bursts, and backpressure compliance.

Parameters:
- DATA_WIDTH, 16, bits per lane sample.
- NUM_CH, 1, number of packed lanes on out_data.
- CNT_WIDTH, 16, width of burst length and sample counters.
- CH_OFFSET, 1, per-lane additive offset; lane k = base + k*CH_OFFSET, mod 2^DATA_WIDTH.
- LFSR_POLY, 16'hB400, Galois feedback mask for PRBS mode; resized to DATA_WIDTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start pulse; honoured in IDLE only
- abort  in  1  stop the burst immediately
- mode  in  2  0 ramp, 1 constant, 2 PRBS, 3 alternate
- start_val  in  DATA_WIDTH  initial value, or PRBS seed
- step  in  DATA_WIDTH  ramp increment
- burst_len  in  CNT_WIDTH  number of beats; 0 = continuous
- gap  in  8  idle cycles between beats (ADC_STIM_GAP_EN builds only)
- out_data  out  NUM_CH*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  beat valid
- out_ready  in  1  sink ready
- out_last  out  1  final beat of a finite burst
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at burst completion
- beat_cnt  out  CNT_WIDTH  accepted beats since the last start

Behaviour:
- Reset values: out_data 0, out_valid 0, out_last 0, busy 0, done 0, beat_cnt 0, FSM IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
  - mode, start_val, step and burst_len are latched on that edge.
  - Later changes to these inputs are ignored until the next start.
  - beat_cnt clears to 0.
- Latency: out_valid rises on the first edge after start. Beat 0 base value = start_val; for PRBS, a seed of 0 is replaced by 1.
- Handshake:
  - A beat is accepted when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - Back-to-back acceptance is allowed with no bubbles (gap = 0 or feature absent).
- Advancing the base value on each accepted beat:
  - ramp: base + step, wraps mod 2^DATA_WIDTH.
  - constant: unchanged.
  - PRBS: (v >> 1) ^ (v[0] ? LFSR_POLY : 0).
  - alternate: ~base.
- Lane offsets are applied combinationally to the registered base and then registered into out_data. There are no extra latency cycles.
- beat_cnt increments on each accepted beat and saturates at all-ones.
- Finite burst (burst_len = N, N > 0):
  - out_last = 1 on beat N-1.
  - After that beat is accepted: RUN -> DONE, out_valid = 0, done = 1 for one cycle, then DONE -> IDLE.
  - N = 1 gives a single beat with out_last = 1.
- Continuous burst (burst_len = 0): out_last is never asserted; the block runs until abort.
- Abort:
  - In RUN, abort forces IDLE on the next edge: out_valid and out_last go to 0.
  - done is not pulsed; beat_cnt keeps its value.
  - Abort may drop a pending unaccepted beat. This is a documented exception to the hold rule.
- Simultaneous events:
  - start and abort in IDLE: abort wins; the block stays IDLE.
  - start in RUN or DONE: ignored.
  - Abort in the same cycle as acceptance of the final beat: that beat counts in beat_cnt; the block goes to IDLE with no done pulse.
- Reset mid-burst: all outputs return to reset values asynchronously.
- busy = 1 in RUN and DONE.

Optional Feature:
- Macro: ADC_STIM_GAP_EN.
- Defined:
  - After each accepted beat, out_valid deasserts for exactly gap cycles, counted by an 8-bit down-counter, before the next beat is presented.
  - The gap value is latched at start.
  - No gap follows the final beat.
  - Abort during a gap goes to IDLE.
- Undefined: the gap port exists but is ignored; no gap counter is synthesised; beats are back-to-back.

Test Plan:
- Ramp: mode 0, start_val 0, step 100, burst_len 100, out_ready = 1 → out_data 0, 100, …, 9900 on consecutive cycles; out_last on 9900; done pulses once; beat_cnt = 100.
- Backpressure: mode 0, start_val 5, step 1, burst_len 4; out_ready low for 3 cycles on beat 1 → value 6 holds stable all 3 cycles; sequence 5, 6, 7, 8 with no loss or duplication.
- PRBS: mode 2, seed 0, DATA_WIDTH 16 → first beats 0x0001, 0xB400, 0x5A00; continuous mode with burst_len = 0 never asserts out_last.
- Multi-lane: NUM_CH 4, CH_OFFSET 0x10, mode 1, start_val 0xFFF8 → lanes 0xFFF8, 0x0008, 0x0018, 0x0028 (wrap checked).
- Abort/edge cases:
  - burst_len 1 → single beat with out_last = 1 and done.
  - Abort on beat 3 of 10 → IDLE next cycle, no done, beat_cnt = 3.
  - start and abort together in IDLE → stays IDLE.
  - Reset mid-burst → all outputs 0.
- ADC_STIM_GAP_EN: gap 2, burst_len 3 → valid pattern 1 0 0 1 0 0 1; no gap after the last beat.
